// File: rtl/calc_ctrl.sv
// Keypad calculator sequencing controller.
// Takes decoded one-cycle key events, runs operand/operator entry and drives
// a registered display value, operator indicator and status flags.
// Multiply is a shift-add over the B bits (LSB first); divide is restoring
// and keeps only the quotient. Both take exactly OPW cycles in S_CALC.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_A    | entering operand A (digits append to A)
//   S_OP   | operator latched, waiting for first digit of B (op replaceable)
//   S_B    | entering operand B; enter starts execution
//   S_CALC | executing; busy, every key event is dropped
//   S_RES  | result shown; digit starts fresh, operator chains on result
//   S_ERR  | overflow / negative / divide by zero; only clear leaves
module calc_ctrl #(
    parameter int OPW        = 14,
    parameter int MAX_DIGITS = 4,
    parameter int MAX_VAL    = 9999
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_valid,
    input  logic [3:0]     key_code,
    output logic [OPW-1:0] disp_value,
    output logic [3:0]     disp_op,
    output logic           busy,
    output logic           err,
    output logic           result_valid
);

    localparam int CW  = $clog2(MAX_DIGITS + 1);
    localparam int ICW = $clog2(OPW);

    localparam logic [CW-1:0]    MAX_DIG_C = CW'(MAX_DIGITS);
    localparam logic [OPW:0]     MAX_VAL_S = (OPW + 1)'(MAX_VAL);
    localparam logic [2*OPW-1:0] MAX_VAL_W = (2 * OPW)'(MAX_VAL);
    localparam logic [ICW-1:0]   ITER_LAST = ICW'(OPW - 1);

    localparam logic [3:0] K_ADD   = 4'd10;
    localparam logic [3:0] K_SUB   = 4'd11;
    localparam logic [3:0] K_MUL   = 4'd12;
    localparam logic [3:0] K_DIV   = 4'd13;
    localparam logic [3:0] K_CLR   = 4'd14;
    localparam logic [3:0] K_ENTER = 4'd15;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_CALC = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic [OPW-1:0]   res_q, res_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d;
    logic [CW-1:0]    cnt_b_q, cnt_b_d;
    logic [3:0]       op_q, op_d;
    // acc: multiply accumulator, or partial remainder in the low OPW+1 bits
    logic [2*OPW-1:0] acc_q, acc_d;
    // mc: shifted multiplicand (multiply only)
    logic [2*OPW-1:0] mc_q, mc_d;
    // mp: multiplier shifting right, or dividend/quotient shifting left
    logic [OPW-1:0]   mp_q, mp_d;
    // iter: down-counter, last iteration when it reads zero
    logic [ICW-1:0]   iter_q, iter_d;

    logic [OPW-1:0]   disp_value_q, disp_value_d;
    logic [3:0]       disp_op_q, disp_op_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             result_valid_q, result_valid_d;

    logic [OPW:0]     sum_w;
    logic [2*OPW-1:0] acc_mul;
    logic [OPW:0]     rem_sh;
    logic [OPW:0]     rem_nx;
    logic             q_bit;
    logic [OPW-1:0]   quo_nx;
    logic             is_digit;
    logic             is_op;

    // Operand is kept at or below 999 whenever a digit is appended, so the
    // OPW-bit result never wraps.
    function automatic logic [OPW-1:0] append_digit(input logic [OPW-1:0] v,
                                                    input logic [3:0]     d);
        return v * OPW'(10) + OPW'(d);
    endfunction

    // State and datapath registers, plus registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_A;
            a_q            <= '0;
            b_q            <= '0;
            res_q          <= '0;
            cnt_a_q        <= '0;
            cnt_b_q        <= '0;
            op_q           <= '0;
            acc_q          <= '0;
            mc_q           <= '0;
            mp_q           <= '0;
            iter_q         <= '0;
            disp_value_q   <= '0;
            disp_op_q      <= '0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            res_q          <= res_d;
            cnt_a_q        <= cnt_a_d;
            cnt_b_q        <= cnt_b_d;
            op_q           <= op_d;
            acc_q          <= acc_d;
            mc_q           <= mc_d;
            mp_q           <= mp_d;
            iter_q         <= iter_d;
            disp_value_q   <= disp_value_d;
            disp_op_q      <= disp_op_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Next-state: key handling outside CALC, one arithmetic step inside CALC
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        iter_d  = iter_q;

        is_digit = (key_code <= 4'd9);
        is_op    = (key_code >= K_ADD) && (key_code <= K_DIV);

        sum_w   = {1'b0, a_q} + {1'b0, b_q};
        acc_mul = acc_q + (mp_q[0] ? mc_q : '0);
        rem_sh  = {acc_q[OPW-1:0], mp_q[OPW-1]};
        if (rem_sh >= {1'b0, b_q}) begin
            rem_nx = rem_sh - {1'b0, b_q};
            q_bit  = 1'b1;
        end else begin
            rem_nx = rem_sh;
            q_bit  = 1'b0;
        end
        quo_nx = {mp_q[OPW-2:0], q_bit};

        if (state_q == S_CALC) begin
            case (op_q)
                K_ADD: begin
                    if (sum_w > MAX_VAL_S) begin
                        state_d = S_ERR;
                    end else begin
                        res_d   = sum_w[OPW-1:0];
                        state_d = S_RES;
                    end
                end
                K_SUB: begin
                    if (b_q > a_q) begin
                        state_d = S_ERR;
                    end else begin
                        res_d   = a_q - b_q;
                        state_d = S_RES;
                    end
                end
                K_MUL: begin
                    acc_d  = acc_mul;
                    mc_d   = mc_q << 1;
                    mp_d   = mp_q >> 1;
                    iter_d = iter_q - 1'b1;
                    if (iter_q == '0) begin
                        if (acc_mul > MAX_VAL_W) begin
                            state_d = S_ERR;
                        end else begin
                            res_d   = acc_mul[OPW-1:0];
                            state_d = S_RES;
                        end
                    end
                end
                default: begin
                    if (b_q == '0) begin
                        state_d = S_ERR;
                    end else begin
                        acc_d  = {{(OPW - 1){1'b0}}, rem_nx};
                        mp_d   = quo_nx;
                        iter_d = iter_q - 1'b1;
                        if (iter_q == '0) begin
                            res_d   = quo_nx;
                            state_d = S_RES;
                        end
                    end
                end
            endcase
        end else if (key_valid) begin
            if (key_code == K_CLR) begin
                state_d = S_A;
                a_d     = '0;
                b_d     = '0;
                res_d   = '0;
                cnt_a_d = '0;
                cnt_b_d = '0;
                op_d    = '0;
            end else if (is_digit) begin
                case (state_q)
                    S_A: begin
                        if (cnt_a_q < MAX_DIG_C) begin
                            a_d = append_digit(a_q, key_code);
                            if (a_q != '0 || key_code != 4'd0)
                                cnt_a_d = cnt_a_q + 1'b1;
                        end
                    end
                    S_OP, S_B: begin
                        state_d = S_B;
                        if (cnt_b_q < MAX_DIG_C) begin
                            b_d = append_digit(b_q, key_code);
                            if (b_q != '0 || key_code != 4'd0)
                                cnt_b_d = cnt_b_q + 1'b1;
                        end
                    end
                    S_RES: begin
                        state_d = S_A;
                        a_d     = OPW'(key_code);
                        b_d     = '0;
                        op_d    = '0;
                        cnt_b_d = '0;
                        cnt_a_d = (key_code != 4'd0) ? CW'(1) : '0;
                    end
                    default: ;
                endcase
            end else if (is_op) begin
                case (state_q)
                    S_A, S_OP: begin
                        op_d    = key_code;
                        state_d = S_OP;
                    end
                    S_RES: begin
                        a_d     = res_q;
                        b_d     = '0;
                        cnt_a_d = '0;
                        cnt_b_d = '0;
                        op_d    = key_code;
                        state_d = S_OP;
                    end
                    default: ;
                endcase
            end else if (key_code == K_ENTER && state_q == S_B) begin
                state_d = S_CALC;
                acc_d   = '0;
                iter_d  = ITER_LAST;
                if (op_q == K_DIV) begin
                    mp_d = a_q;
                    mc_d = '0;
                end else begin
                    mp_d = b_q;
                    mc_d = {{OPW{1'b0}}, a_q};
                end
            end
        end
    end

    // Outputs derived from the upcoming state so they register with it
    always_comb begin
        disp_value_d   = '0;
        disp_op_d      = '0;
        busy_d         = (state_d == S_CALC);
        err_d          = (state_d == S_ERR);
        result_valid_d = (state_q == S_CALC) && (state_d == S_RES);
        case (state_d)
            S_A, S_OP:   disp_value_d = a_d;
            S_B, S_CALC: disp_value_d = b_d;
            S_RES:       disp_value_d = res_d;
            default:     disp_value_d = '0;
        endcase
        if (state_d == S_OP || state_d == S_B || state_d == S_CALC)
            disp_op_d = op_d;
    end

    assign disp_value   = disp_value_q;
    assign disp_op      = disp_op_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: keys driven on the falling edge, expected outcomes of
// each enter queued and retired when the DUT reports a result or an error.
module tb_calc_ctrl;

    localparam int OPW = 14;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           key_valid = 1'b0;
    logic [3:0]     key_code = 4'd0;
    logic [OPW-1:0] disp_value;
    logic [3:0]     disp_op;
    logic           busy;
    logic           err;
    logic           result_valid;

    typedef struct {
        int err;
        int val;
        int busy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   busy_run = 0;
    logic busy_prev = 1'b0;
    logic err_prev = 1'b0;
    logic rv_prev = 1'b0;

    calc_ctrl #(.OPW(OPW), .MAX_DIGITS(4), .MAX_VAL(9999)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .disp_value   (disp_value),
        .disp_op      (disp_op),
        .busy         (busy),
        .err          (err),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int want);
        total++;
        if (obs != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    function automatic exp_t model(input int a, input int op, input int b);
        exp_t e;
        e.err  = 0;
        e.val  = 0;
        e.busy = 1;
        case (op)
            10: begin
                if (a + b > 9999) e.err = 1;
                else e.val = a + b;
            end
            11: begin
                if (b > a) e.err = 1;
                else e.val = a - b;
            end
            12: begin
                e.busy = 14;
                if (a * b > 9999) e.err = 1;
                else e.val = a * b;
            end
            default: begin
                if (b == 0) e.err = 1;
                else begin
                    e.busy = 14;
                    e.val  = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Called at a falling edge; returns at the next one with key_valid low.
    task automatic press(input int code);
        key_valid = 1'b1;
        key_code  = 4'(code);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic key_num(input int v);
        int dg[8];
        int n;
        n = 0;
        if (v == 0) begin
            press(0);
        end else begin
            while (v > 0 && n < 8) begin
                dg[n] = v % 10;
                v = v / 10;
                n++;
            end
            for (int i = n - 1; i >= 0; i--) press(dg[i]);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("done_timeout", exp_q.size(), 0);
    endtask

    task automatic calc(input int a, input int op, input int b);
        key_num(a);
        press(op);
        key_num(b);
        exp_q.push_back(model(a, op, b));
        press(15);
        wait_done();
    endtask

    // Scoreboard retirement and result_valid pulse-width checks
    always @(negedge clk) begin
        exp_t e;
        if (rv_prev) check("rv_width", int'(result_valid), 0);
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                check("rv_spurious", int'(result_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("res_err", int'(err), e.err);
                check("res_val", int'(disp_value), e.val);
                check("res_busy", busy_run, e.busy);
            end
        end else if (err && !err_prev && busy_prev) begin
            if (exp_q.size() == 0) begin
                check("err_spurious", int'(err), 0);
            end else begin
                e = exp_q.pop_front();
                check("res_err", int'(err), e.err);
                check("err_disp", int'(disp_value), 0);
                check("res_busy", busy_run, e.busy);
            end
        end
        if (busy) busy_run = busy_prev ? busy_run + 1 : 1;
        busy_prev = busy;
        err_prev  = err;
        rv_prev   = result_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_disp", int'(disp_value), 0);
        check("rst_op", int'(disp_op), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_rv", int'(result_valid), 0);

        calc(12, 10, 34);
        check("add_disp", int'(disp_value), 46);

        calc(99, 12, 101);
        check("mul_err", int'(err), 0);

        press(14);
        calc(100, 12, 100);
        check("ovf_err", int'(err), 1);
        press(5);
        press(15);
        check("err_hold", int'(err), 1);
        check("err_hold_disp", int'(disp_value), 0);
        press(14);
        check("clr_err", int'(err), 0);
        check("clr_disp", int'(disp_value), 0);

        calc(7, 13, 0);
        check("div0_err", int'(err), 1);
        press(14);

        calc(3, 11, 5);
        check("sub_err", int'(err), 1);
        press(14);

        key_num(12345);
        check("dig_limit", int'(disp_value), 1234);
        press(14);
        key_num(0);
        key_num(0);
        key_num(7);
        check("lead_zero", int'(disp_value), 7);
        key_num(123);
        check("lead_more", int'(disp_value), 7123);
        press(9);
        check("lead_full", int'(disp_value), 7123);
        press(14);

        calc(8, 13, 3);
        press(12);
        check("chain_a", int'(disp_value), 2);
        check("chain_op", int'(disp_op), 12);
        key_num(5);
        exp_q.push_back(model(2, 12, 5));
        press(15);
        wait_done();
        press(6);
        check("res_digit", int'(disp_value), 6);
        check("res_digit_op", int'(disp_op), 0);
        press(14);

        key_num(9);
        press(10);
        press(11);
        check("op_replace", int'(disp_op), 11);
        key_num(4);
        press(12);
        check("op_in_b", int'(disp_op), 11);
        check("op_in_b_disp", int'(disp_value), 4);
        exp_q.push_back(model(9, 11, 4));
        press(15);
        wait_done();
        press(14);

        key_num(12);
        press(12);
        key_num(12);
        exp_q.push_back(model(12, 12, 12));
        press(15);
        repeat (2) @(negedge clk);
        press(14);
        check("calc_busy", int'(busy), 1);
        wait_done();
        press(14);

        key_num(12);
        press(12);
        key_num(12);
        press(15);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_disp", int'(disp_value), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_op", int'(disp_op), 0);
        check("abort_rv", int'(result_valid), 0);
        repeat (20) @(negedge clk);
        press(5);
        check("after_abort", int'(disp_value), 5);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
Sequencing controller for the keypad calculator. It consumes one-cycle key events, which are decoded 4-bit key codes, and runs the entry state machine. States cover operand A entry, operator entry, operand B entry, execution, result and error. Execution uses a multi-cycle shift-add multiplier and a restoring divider. It drives the display value, operator indicator, busy, error and result-valid outputs consumed by the display driver.

Parameters:
OPW, 14, operand/result width in bits (unsigned); must hold MAX_VAL
MAX_DIGITS, 4, maximum decimal digits per operand
MAX_VAL, 9999, largest legal result; anything above it is an error

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
key_valid  input  1  one-cycle pulse; key_code valid this cycle
key_code  input  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 clear, 15 enter
disp_value  output  OPW  value to show (unsigned binary)
disp_op  output  4  latched operator code 10-13; 0 when none
busy  output  1  high while in CALC; key events are dropped
err  output  1  high while in ERR
result_valid  output  1  one-cycle pulse when a result is written

Behaviour:
- Reset (rst=1 at posedge): state=S_A; A=B=result=0; digit counts=0; op=0; all outputs 0. rst has priority over key_valid.
- All outputs are registered. Keys are acted on only at posedges where key_valid=1.
- Digit entry (in S_A into A; in S_B or S_OP into B, with S_OP moving to S_B):
  - If digit count < MAX_DIGITS: operand <= operand*10 + d; count++.
  - Otherwise the digit is ignored.
  - A leading zero (operand==0 and d==0) is accepted but does not increment the count.
- Operator (10-13):
  - In S_A: op<=code; go to S_OP.
  - In S_OP: op is replaced.
  - In S_B: ignored.
  - In S_RES: A<=result, op<=code, B=0; go to S_OP (chaining).
- Enter (15):
  - In S_B: go to S_CALC.
  - In S_A, S_OP, S_RES: ignored.
- Clear (14): in any state except S_CALC, returns to reset values except that result_valid=0; state=S_A.
- S_CALC: busy=1; every key_valid is discarded, including clear. Enter sampled at edge k:
  - add/sub: result registered at edge k+1, state=S_RES, result_valid=1 for the cycle after edge k+1.
  - mul: shift-add over B bits, LSB first, with a 2*OPW-bit accumulator. Exactly OPW CALC edges (k+1..k+OPW); result_valid after edge k+OPW.
  - div: restoring, quotient only (remainder discarded), exactly OPW CALC edges.
- Errors go to S_ERR instead of S_RES, with result_valid=0:
  - add > MAX_VAL
  - sub with B > A
  - mul product > MAX_VAL (full 2*OPW product compared)
  - div with B==0 (detected at edge k+1, no iteration)
- S_ERR: err=1, disp_value=0; only clear leaves it.
- S_RES: digit d clears A, B and op, loads A=d (count=1 unless d==0), state=S_A.
- disp_value by state:
  - S_A, S_OP: A
  - S_B: B
  - S_CALC: B (held)
  - S_RES: result
  - S_ERR: 0
- disp_op = op in S_OP, S_B, S_CALC; 0 otherwise.
- rst asserted mid-CALC aborts the iteration immediately; no result_valid is produced.

Test Plan:
- Keys 1,2,+,3,4,enter → disp_value 46; result_valid one cycle, the cycle after the edge following enter; busy high exactly 1 cycle.
- Keys 9,9,*,1,0,1,enter → busy high 14 cycles, disp_value 9999, err=0. Then clear, 1,0,0,*,1,0,0,enter → err=1, disp_value 0, result_valid never pulses.
- Keys 7,/,0,enter → err=1 after 1 CALC cycle. Any digit or enter is ignored. Clear → state S_A, disp_value 0, err=0.
- Keys 3,-,5,enter → err. Keys 1,2,3,4,5 → disp_value 1234. Keys 0,0,7 → disp_value 7 with count=1, so 3 more digits are accepted.
- Keys 8,/,3,enter → 2. Then *,5,enter → 10 (chaining). Then digit 6 → disp_value 6, disp_op 0.
- Mid-multiply: clear pulse during CALC is ignored and the result completes. rst pulse during CALC → all outputs 0 next cycle, no result_valid.
